// File: rtl/mux_n_stream.sv
// NUM_CH-way valid/ready stream mux onto one registered output; external select or round-robin, with packet lock.
// Define MUX_N_STREAM_SEL_CHECK_EN to compile select/grant/stability assertions.
module mux_n_stream #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int MODE   = 0,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_last,
   input  logic [SEL_W-1:0]        sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_last,
   output logic [SEL_W-1:0]        out_chan
);

   logic [WIDTH-1:0]  ch_data [NUM_CH];
   logic [NUM_CH-1:0] grant;
   logic [SEL_W-1:0]  grant_idx;
   logic              grant_any;
   logic              load_en;
   logic [SEL_W:0]    rr_cand;
   logic [SEL_W-1:0]  rr_next;
   logic              lock_reg;
   logic [SEL_W-1:0]  lock_ch_reg;
   logic [SEL_W-1:0]  rr_ptr_reg;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
   end

   assign load_en  = !out_valid || out_ready;
   assign in_ready = load_en ? grant : '0;
   assign rr_next  = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      rr_cand   = '0;
      if (lock_reg) begin
         if (in_valid[lock_ch_reg]) begin
            grant_any = 1'b1;
            grant_idx = lock_ch_reg;
         end
      end else if (MODE == 0) begin
         if (int'(sel) < NUM_CH && in_valid[sel]) begin
            grant_any = 1'b1;
            grant_idx = sel;
         end
      end else begin
         // Scan downward in priority so the nearest valid channel at/after rr_ptr wins last.
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            rr_cand = {1'b0, rr_ptr_reg} + (SEL_W+1)'(k);
            if (rr_cand >= (SEL_W+1)'(NUM_CH))
               rr_cand = rr_cand - (SEL_W+1)'(NUM_CH);
            if (in_valid[rr_cand[SEL_W-1:0]]) begin
               grant_any = 1'b1;
               grant_idx = rr_cand[SEL_W-1:0];
            end
         end
      end
      if (grant_any)
         grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_last    <= 1'b0;
         out_chan    <= '0;
         lock_reg    <= 1'b0;
         lock_ch_reg <= '0;
         rr_ptr_reg  <= '0;
      end else if (load_en) begin
         out_valid <= grant_any;
         if (grant_any) begin
            out_data <= ch_data[grant_idx];
            out_last <= in_last[grant_idx];
            out_chan <= grant_idx;
            lock_reg <= !in_last[grant_idx];
            if (!in_last[grant_idx])
               lock_ch_reg <= grant_idx;
            else if (MODE != 0)
               rr_ptr_reg <= rr_next;
         end
      end
   end

`ifdef MUX_N_STREAM_SEL_CHECK_EN
   logic [NUM_CH-1:0] stall_reg;
   logic [WIDTH-1:0]  held_data [NUM_CH];
   logic [NUM_CH-1:0] held_last;

   always_comb begin
      if (rst_n === 1'b1) begin
         if (MODE == 0 && |in_valid)
            assert (!$isunknown(sel) && int'(sel) < NUM_CH)
               else $error("mux_n_stream: sel=%0d invalid while in_valid=%b", sel, in_valid);
         assert ($onehot0(grant))
            else $error("mux_n_stream: grant %b not one-hot0", grant);
      end
   end

   // A channel left valid but not ready must present identical data/last until it transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_reg <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (stall_reg[i] && in_valid[i])
               assert (ch_data[i] == held_data[i] && in_last[i] == held_last[i])
                  else $error("mux_n_stream: ch%0d payload changed while stalled", i);
         end
         stall_reg <= in_valid & ~in_ready;
      end
   end

   always_ff @(posedge clk) begin
      held_data <= ch_data;
      held_last <= in_last;
   end
`endif

endmodule

// File: tb/tb_mux_n_stream.sv
// Bench for mux_n_stream: three instances (ext-sel x4, round-robin x4, ext-sel x3) against a cycle-level reference model.
module tb_mux_n_stream;
   localparam int ND = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0]   v    [ND];
   logic [3:0]   l    [ND];
   logic [127:0] dpk  [ND];
   logic [1:0]   s    [ND];
   logic         ordy [ND];
   logic [3:0]   rdy  [ND];
   logic [2:0]   rdy_c;
   logic         ov   [ND];
   logic [31:0]  od   [ND];
   logic         ol   [ND];
   logic [1:0]   oc   [ND];

   assign rdy[2] = {1'b0, rdy_c};

   mux_n_stream #(.WIDTH(32), .NUM_CH(4), .MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(rdy[0]), .in_data(dpk[0]),
      .in_last(l[0]), .sel(s[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
      .out_last(ol[0]), .out_chan(oc[0]));

   mux_n_stream #(.WIDTH(32), .NUM_CH(4), .MODE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(rdy[1]), .in_data(dpk[1]),
      .in_last(l[1]), .sel(s[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
      .out_last(ol[1]), .out_chan(oc[1]));

   mux_n_stream #(.WIDTH(32), .NUM_CH(3), .MODE(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(v[2][2:0]), .in_ready(rdy_c), .in_data(dpk[2][95:0]),
      .in_last(l[2][2:0]), .sel(s[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
      .out_last(ol[2]), .out_chan(oc[2]));

   int nch  [ND] = '{4, 4, 3};
   int mode [ND] = '{0, 1, 0};

   // Reference model: output slot contents, packet owner (-1 = none), next round-robin start.
   bit          m_full  [ND];
   logic [31:0] m_data  [ND];
   bit          m_last  [ND];
   int          m_chan  [ND];
   int          m_owner [ND];
   int          m_next  [ND];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t: got %0h want %0h", nm, d, $time, act, exp);
      end
   endtask

   function automatic int exp_grant(input int d);
      if (m_owner[d] >= 0)
         return v[d][m_owner[d]] ? m_owner[d] : -1;
      if (mode[d] == 0)
         return (int'(s[d]) < nch[d] && v[d][s[d]]) ? int'(s[d]) : -1;
      for (int k = 0; k < nch[d]; k++)
         if (v[d][(m_next[d] + k) % nch[d]])
            return (m_next[d] + k) % nch[d];
      return -1;
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         int g;
         bit can;
         logic [3:0] er;
         if (!rst_n) begin
            m_full[d]  = 1'b0;
            m_data[d]  = '0;
            m_last[d]  = 1'b0;
            m_chan[d]  = 0;
            m_owner[d] = -1;
            m_next[d]  = 0;
            chk("rst_out_valid", d, 32'(ov[d]), 0);
            chk("rst_out_data", d, od[d], 0);
            chk("rst_out_chan", d, 32'(oc[d]), 0);
         end else begin
            chk("out_valid", d, 32'(ov[d]), 32'(m_full[d]));
            chk("out_data", d, od[d], m_data[d]);
            chk("out_last", d, 32'(ol[d]), 32'(m_last[d]));
            chk("out_chan", d, 32'(oc[d]), m_chan[d]);
            g   = exp_grant(d);
            can = !m_full[d] || ordy[d];
            er  = (can && g >= 0) ? 4'(1 << g) : 4'b0;
            chk("in_ready", d, 32'(rdy[d]), 32'(er));
            if (can) begin
               m_full[d] = (g >= 0);
               if (g >= 0) begin
                  m_data[d]  = dpk[d][g*32 +: 32];
                  m_last[d]  = l[d][g];
                  m_chan[d]  = g;
                  m_owner[d] = l[d][g] ? -1 : g;
                  if (mode[d] == 1 && l[d][g])
                     m_next[d] = (g + 1) % nch[d];
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) begin
         v[d] = '0; l[d] = '0; dpk[d] = '0; s[d] = '0; ordy[d] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("lit_reset_valid", 0, 32'(ov[0]), 0);
      chk("lit_reset_chan", 1, 32'(oc[1]), 0);

      // Single beat on ch2 via sel
      s[0] = 2'd2; v[0] = 4'b0100; dpk[0][64 +: 32] = 32'hA5A5_0002; l[0] = 4'b0100;
      #1 chk("lit_t1_ready", 0, 32'(rdy[0]), 32'h4);
      step(); v[0] = '0; l[0] = '0; #1;
      chk("lit_t1_valid", 0, 32'(ov[0]), 1);
      chk("lit_t1_data", 0, od[0], 32'hA5A5_0002);
      chk("lit_t1_chan", 0, 32'(oc[0]), 2);
      chk("lit_t1_last", 0, 32'(ol[0]), 1);

      // 3-beat packet on ch1, sel moves to ch3 mid-packet
      s[0] = 2'd1; v[0] = 4'b0010; dpk[0][32 +: 32] = 32'hB000_0001; l[0] = 4'b0000;
      #1 chk("lit_t2_ready0", 0, 32'(rdy[0]), 32'h2);
      step();
      s[0] = 2'd3; v[0] = 4'b1010; dpk[0][32 +: 32] = 32'hB000_0002;
      dpk[0][96 +: 32] = 32'hC000_0003; l[0] = 4'b1000; #1;
      chk("lit_t2_lock_ready", 0, 32'(rdy[0]), 32'h2);
      chk("lit_t2_beat1", 0, od[0], 32'hB000_0001);
      step();
      dpk[0][32 +: 32] = 32'hB000_0003; l[0] = 4'b1010; #1;
      chk("lit_t2_lock_ready2", 0, 32'(rdy[0]), 32'h2);
      chk("lit_t2_beat2", 0, od[0], 32'hB000_0002);
      step();
      v[0] = 4'b1000; #1;
      chk("lit_t2_beat3", 0, od[0], 32'hB000_0003);
      chk("lit_t2_beat3_last", 0, 32'(ol[0]), 1);
      chk("lit_t2_ch3_ready", 0, 32'(rdy[0]), 32'h8);
      step();
      v[0] = '0; l[0] = '0; #1;
      chk("lit_t2_ch3_data", 0, od[0], 32'hC000_0003);
      chk("lit_t2_ch3_chan", 0, 32'(oc[0]), 3);

      // Round-robin over four always-valid single-beat channels
      v[1] = 4'hF; l[1] = 4'hF; ordy[1] = 1'b1;
      dpk[1] = {32'h0000_00D3, 32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};
      for (int i = 0; i < 5; i++) begin
         step(); #1;
         chk("lit_t3_rr_chan", 1, 32'(oc[1]), i % 4);
      end

      // Backpressure for three cycles, then drain+load with no bubble
      ordy[1] = 1'b0;
      #1 chk("lit_t4_stall_ready", 1, 32'(rdy[1]), 0);
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         chk("lit_t4_hold_data", 1, od[1], 32'h0000_00D0);
         chk("lit_t4_hold_ready", 1, 32'(rdy[1]), 0);
      end
      ordy[1] = 1'b1;
      #1 chk("lit_t4_release_ready", 1, 32'(rdy[1]), 32'h2);
      step(); #1;
      chk("lit_t4_nobubble_valid", 1, 32'(ov[1]), 1);
      chk("lit_t4_nobubble_chan", 1, 32'(oc[1]), 1);
      v[1] = '0;

      // NUM_CH=3 with out-of-range sel
      s[2] = 2'd0; v[2] = 4'b0111; l[2] = 4'b0111; dpk[2][31:0] = 32'hE000_0000;
      step(); s[2] = 2'd3; #1;
      chk("lit_t5_oor_ready", 2, 32'(rdy[2]), 0);
      step(); v[2] = '0; #1;
      chk("lit_t5_valid_drop", 2, 32'(ov[2]), 0);
      chk("lit_t5_data_hold", 2, od[2], 32'hE000_0000);

      // Reset while both ext-sel and round-robin instances are locked mid-packet
      v[1] = 4'b0100; l[1] = 4'b0000;
      s[0] = 2'd0; v[0] = 4'b0001; l[0] = 4'b0000;
      step(); #1;
      chk("lit_t6_pre_valid_a", 0, 32'(ov[0]), 1);
      chk("lit_t6_pre_valid_b", 1, 32'(ov[1]), 1);
      rst_n = 1'b0;
      v[1] = 4'hF; l[1] = 4'hF;
      s[0] = 2'd3; v[0] = 4'b1000; l[0] = 4'b1000;
      #1;
      chk("lit_t6_async_valid_a", 0, 32'(ov[0]), 0);
      chk("lit_t6_async_valid_b", 1, 32'(ov[1]), 0);
      step(); step();
      rst_n = 1'b1; #1;
      chk("lit_t6_rr_ch0_ready", 1, 32'(rdy[1]), 32'h1);
      chk("lit_t6_sel_ready", 0, 32'(rdy[0]), 32'h8);
      step(); #1;
      chk("lit_t6_rr_chan", 1, 32'(oc[1]), 0);
      chk("lit_t6_sel_chan", 0, 32'(oc[0]), 3);

      // Randomized traffic on all three instances
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         rst_n = ($urandom_range(599) != 0);
         for (int d = 0; d < ND; d++) begin
            v[d]    = 4'($urandom) | 4'($urandom);
            l[d]    = 4'($urandom) & 4'($urandom);
            dpk[d]  = {$urandom, $urandom, $urandom, $urandom};
            ordy[d] = ($urandom_range(3) != 0);
            if ($urandom_range(4) == 0)
               s[d] = 2'($urandom);
         end
      end

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
